sd_spi_responder: RTL and testbench

SPI-mode SD card responder: the card-side end of the SD SPI command link.
- Oversamples host sck/ss/mosi in the clk domain and deframes 48-bit commands.
- Presents each command to card logic and serialises the 8-bit R1 response back on miso.
- Used as an SD card model on the FPGA and as the bench partner for the host SPI controller.

---
 rtl/sd_spi_pkg.sv | 29 ++
 rtl/sd_crc7.sv | 24 ++
 rtl/sd_spi_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_sd_spi_responder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// rtl/sd_spi_pkg.sv - shared types and constants for the SD SPI responder
package sd_spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    WAIT = 2'd2,
    SEND = 2'd3
  } state_t;

  localparam int unsigned FRAME_W = 48;

  // R1 flag bit positions
  localparam int unsigned R1_IDLE_BIT        = 0;
  localparam int unsigned R1_ILLEGAL_CMD_BIT = 2;
  localparam int unsigned R1_CRC_ERR_BIT     = 3;

  localparam logic [7:0] R1_COM_CRC_ERR = 8'h01 << R1_CRC_ERR_BIT;

  // x^7 + x^3 + 1, x^7 term implicit
  localparam logic [6:0] CRC7_POLY = 7'h09;

  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7, one message bit per enable, MSB first
module sd_crc7
  import sd_spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  // CRC register: clear has priority over accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc7_next(crc, din);
    end
  end

endmodule

// File: rtl/sd_spi_responder.sv
// rtl/sd_spi_responder.sv - SD SPI-mode command deframer and R1 responder (option: SD_RESP_CRC7_CHECK_EN)
module sd_spi_responder
  import sd_spi_pkg::*;
#(
  parameter int unsigned NCR_MIN    = 1,
  parameter int unsigned NCR_MAX    = 8,
  parameter logic [7:0]  TIMEOUT_R1 = 8'h04
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        ss,
  input  logic        mosi,
  output logic        miso,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  input  logic [7:0]  resp,
  input  logic        resp_valid,
  output logic        busy
);

  localparam logic [3:0] NCR_MIN_C = 4'(NCR_MIN);
  localparam logic [3:0] NCR_MAX_C = 4'(NCR_MAX);
  localparam logic [5:0] LAST_BIT  = 6'(FRAME_W - 1);
  localparam logic [5:0] CRC_BITS  = 6'(FRAME_W - 8);

  state_t state, state_next;

  logic [1:0] sck_sync, ss_sync, mosi_sync;
  logic       sck_last;
  logic       sck_rise, sck_fall, ss_s, mosi_s;

  logic [FRAME_W-2:0] shreg;
  logic [FRAME_W-1:0] frame;
  logic [5:0]         bit_cnt;
  logic [2:0]         tx_bit;
  logic [3:0]         ncr_cnt;
  logic               byte_done;
  logic               resp_held;
  logic [7:0]         resp_reg, tx_reg, r1_load;
  logic               start_bit, frame_end, frame_ok, crc_ok, boundary, have_resp, go_send;

  assign ss_s     = ss_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign sck_rise = sck_sync[1] & ~sck_last;
  assign sck_fall = ~sck_sync[1] & sck_last;
  assign busy     = (state != IDLE);

  // Two-flop synchronisers for the host pins plus sck edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= 2'b00;
      ss_sync   <= 2'b11;
      mosi_sync <= 2'b11;
      sck_last  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], sck};
      ss_sync   <= {ss_sync[0], ss};
      mosi_sync <= {mosi_sync[0], mosi};
      sck_last  <= sck_sync[1];
    end
  end

`ifdef SD_RESP_CRC7_CHECK_EN
  logic [6:0] crc;
  logic       crc_en, crc_clr;

  // Feed the start bit and the next 39 bits (frame bits 47:8) into the CRC
  assign crc_en  = sck_rise && (start_bit || ((state == RECV) && (bit_cnt < CRC_BITS)));
  assign crc_clr = (state == IDLE) && !crc_en;
  assign crc_ok  = (crc == frame[7:1]);

  sd_crc7 u_crc7 (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (mosi_s),
    .crc (crc)
  );
`else
  assign crc_ok = 1'b1;
`endif

  // Frame decode, byte-boundary decisions and next-state selection
  always_comb begin
    state_next = state;
    frame      = {shreg, mosi_s};
    start_bit  = (state == IDLE) && sck_rise && !mosi_s;
    frame_end  = (state == RECV) && sck_rise && (bit_cnt == LAST_BIT);
    frame_ok   = !frame[FRAME_W-1] && frame[FRAME_W-2] && frame[0];
    boundary   = sck_fall && byte_done;
    have_resp  = resp_held || resp_valid;
    go_send    = 1'b0;
    r1_load    = TIMEOUT_R1;
    // a response strobed on the timeout boundary still beats the timeout code
    if (have_resp && (ncr_cnt >= NCR_MIN_C)) begin
      go_send = boundary;
      r1_load = resp_held ? resp_reg : resp;
    end else if (ncr_cnt == NCR_MAX_C) begin
      go_send = boundary;
    end
    if (ss_s) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_bit) state_next = RECV;
        RECV:    if (frame_end) state_next = frame_ok ? WAIT : IDLE;
        WAIT:    if (go_send) state_next = SEND;
        SEND:    if (boundary) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Receive shifter, filler/response serialiser and command outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso      <= 1'b1;
      cmd_valid <= 1'b0;
      cmd_index <= '0;
      cmd_arg   <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      tx_bit    <= '0;
      ncr_cnt   <= '0;
      byte_done <= 1'b0;
      resp_held <= 1'b0;
      resp_reg  <= '0;
      tx_reg    <= 8'hFF;
    end else begin
      cmd_valid <= 1'b0;
      if (ss_s) begin
        miso      <= 1'b1;
        bit_cnt   <= '0;
        tx_bit    <= '0;
        ncr_cnt   <= '0;
        byte_done <= 1'b0;
        resp_held <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            miso <= 1'b1;
            if (start_bit) begin
              shreg   <= frame[FRAME_W-2:0];
              bit_cnt <= 6'd1;
            end
          end
          RECV: begin
            if (sck_rise) begin
              shreg   <= frame[FRAME_W-2:0];
              bit_cnt <= bit_cnt + 6'd1;
              if (frame_end) begin
                bit_cnt   <= '0;
                tx_bit    <= '0;
                ncr_cnt   <= '0;
                // the fall after the last command bit starts the first filler byte
                byte_done <= frame_ok;
                resp_held <= 1'b0;
                if (frame_ok && crc_ok) begin
                  cmd_valid <= 1'b1;
                  cmd_index <= frame[45:40];
                  cmd_arg   <= frame[39:8];
                end else if (frame_ok) begin
                  resp_held <= 1'b1;
                  resp_reg  <= R1_COM_CRC_ERR;
                end
              end
            end
          end
          WAIT: begin
            if (resp_valid && !resp_held) begin
              resp_held <= 1'b1;
              resp_reg  <= resp;
            end
            if (sck_rise) begin
              tx_bit <= tx_bit + 3'd1;
              if (tx_bit == 3'd7) begin
                ncr_cnt   <= ncr_cnt + 4'd1;
                byte_done <= 1'b1;
              end
            end
            if (sck_fall) begin
              byte_done <= 1'b0;
              if (go_send) begin
                miso      <= r1_load[7];
                tx_reg    <= {r1_load[6:0], 1'b1};
                tx_bit    <= '0;
                resp_held <= 1'b0;
              end else begin
                miso <= 1'b1;
              end
            end
          end
          SEND: begin
            if (sck_rise) begin
              tx_bit <= tx_bit + 3'd1;
              if (tx_bit == 3'd7) byte_done <= 1'b1;
            end
            if (sck_fall) begin
              if (byte_done) begin
                byte_done <= 1'b0;
                miso      <= 1'b1;
              end else begin
                miso   <= tx_reg[7];
                tx_reg <= {tx_reg[6:0], 1'b1};
              end
            end
          end
          default: miso <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// tb/tb_sd_spi_responder.sv - scoreboard bench for sd_spi_responder (covers SD_RESP_CRC7_CHECK_EN when defined)
module tb_sd_spi_responder;

  localparam int         NCR_MIN    = 1;
  localparam int         NCR_MAX    = 8;
  localparam logic [7:0] TIMEOUT_R1 = 8'h04;
  localparam int         RD_LIMIT   = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        sck;
  logic        ss;
  logic        mosi;
  logic        miso;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [7:0]  resp;
  logic        resp_valid;
  logic        busy;

  always #5 clk = ~clk;

  sd_spi_responder #(
    .NCR_MIN    (NCR_MIN),
    .NCR_MAX    (NCR_MAX),
    .TIMEOUT_R1 (TIMEOUT_R1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sck        (sck),
    .ss         (ss),
    .mosi       (mosi),
    .miso       (miso),
    .cmd_valid  (cmd_valid),
    .cmd_index  (cmd_index),
    .cmd_arg    (cmd_arg),
    .resp       (resp),
    .resp_valid (resp_valid),
    .busy       (busy)
  );

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
  } cmd_t;

  typedef struct {
    bit         found;
    int         ncr;
    logic [7:0] r1;
  } rsp_t;

  cmd_t exp_cmd_q[$];
  rsp_t exp_rsp_q[$];
  rsp_t obs_rsp_q[$];

  int checks   = 0;
  int failures = 0;

  bit         rsp_en    = 1'b0;
  int         rsp_delay = 0;
  logic [7:0] rsp_byte  = 8'h00;
  bit         rsp_dup   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] head;
    head = {2'b01, idx, arg};
    return {head, crc7(head), 1'b1};
  endfunction

  function automatic rsp_t mk_rsp(input bit found, input int ncr, input logic [7:0] r1);
    rsp_t r;
    r.found = found;
    r.ncr   = ncr;
    r.r1    = r1;
    return r;
  endfunction

  task automatic spi_bit(input logic d, output logic q);
    mosi = d;
    #60;
    q   = miso;
    sck = 1'b1;
    #60;
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] d, output logic [7:0] q);
    logic b;
    q = '0;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(d[i], b);
      q = {q[6:0], b};
    end
  endtask

  task automatic read_resp(output rsp_t o);
    logic [7:0] v;
    o = mk_rsp(1'b0, 0, 8'hFF);
    for (int b = 0; b < RD_LIMIT && !o.found; b++) begin
      spi_byte(8'hFF, v);
      if (v != 8'hFF) begin
        o.found = 1'b1;
        o.r1    = v;
      end else begin
        o.ncr++;
      end
    end
  endtask

  // One host transaction: optional filler, full or truncated frame, then response readout
  task automatic run_txn(input logic [47:0] f, input int pre_ff, input int nbits,
                         input bit expect_cmd, input rsp_t e);
    logic [7:0] junk;
    logic       b;
    rsp_t       o;
    ss = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < pre_ff; i++) spi_byte(8'hFF, junk);
    if (expect_cmd) exp_cmd_q.push_back('{f[45:40], f[39:8]});
    if (nbits == 48) exp_rsp_q.push_back(e);
    for (int i = 47; i > 47 - nbits; i--) spi_bit(f[i], b);
    if (nbits < 48) begin
      ss = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("abort_busy", busy, 0);
      check("abort_miso", miso, 1);
    end else begin
      check("busy_after_frame", busy, e.found);
      read_resp(o);
      obs_rsp_q.push_back(o);
      if (o.found) begin
        repeat (5) @(posedge clk);
        #1;
        check("busy_after_r1", busy, 0);
        check("miso_after_r1", miso, 1);
      end
    end
    ss   = 1'b1;
    mosi = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Card-logic model: answers each command after a programmed delay
  initial begin
    resp_valid = 1'b0;
    resp       = 8'h00;
    forever begin
      @(negedge clk);
      if (cmd_valid && rsp_en) begin
        repeat (rsp_delay) @(negedge clk);
        resp       = rsp_byte;
        resp_valid = 1'b1;
        @(negedge clk);
        resp_valid = 1'b0;
        if (rsp_dup) begin
          @(negedge clk);
          resp       = rsp_byte ^ 8'h15;
          resp_valid = 1'b1;
          @(negedge clk);
          resp_valid = 1'b0;
        end
      end
    end
  end

  // Command monitor
  initial begin
    cmd_t e;
    forever begin
      @(negedge clk);
      if (cmd_valid) begin
        if (exp_cmd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL cmd_unexpected: got index %0d arg %0h, none expected", cmd_index, cmd_arg);
        end else begin
          e = exp_cmd_q.pop_front();
          check("cmd_index", cmd_index, e.idx);
          check("cmd_arg", cmd_arg, e.arg);
        end
      end
    end
  end

  // Response monitor
  initial begin
    rsp_t o;
    rsp_t e;
    forever begin
      wait (obs_rsp_q.size() > 0);
      o = obs_rsp_q.pop_front();
      if (exp_rsp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got r1 %0h after %0d bytes, none expected", o.r1, o.ncr);
      end else begin
        e = exp_rsp_q.pop_front();
        check("rsp_found", o.found, e.found);
        check("rsp_ncr", o.ncr, e.ncr);
        check("rsp_r1", o.r1, e.r1);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] f;
    logic [7:0]  r1;
    int          kind;
    int          pre;
    int          nb;
    rst  = 1'b1;
    ss   = 1'b1;
    sck  = 1'b0;
    mosi = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_miso", miso, 1);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_index", cmd_index, 0);
    check("rst_cmd_arg", cmd_arg, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    rsp_en = 1; rsp_delay = 2; rsp_byte = 8'h01; rsp_dup = 0;
    run_txn(48'h400000000095, 0, 48, 1'b1, mk_rsp(1'b1, NCR_MIN, 8'h01));

    rsp_en = 0;
    run_txn(48'h48000001AA87, 0, 48, 1'b1, mk_rsp(1'b1, NCR_MAX, TIMEOUT_R1));

    rsp_en = 1; rsp_delay = 5; rsp_byte = 8'h00;
    run_txn(make_frame(6'd17, 32'h00001000), 2, 48, 1'b1, mk_rsp(1'b1, NCR_MIN, 8'h00));

    run_txn(48'h400000000095, 0, 20, 1'b0, mk_rsp(1'b0, 0, 8'hFF));
    rsp_delay = 0; rsp_byte = 8'h01;
    run_txn(48'h400000000095, 0, 48, 1'b1, mk_rsp(1'b1, NCR_MIN, 8'h01));

    run_txn(48'h400000000094, 0, 48, 1'b0, mk_rsp(1'b0, RD_LIMIT, 8'hFF));

    rsp_delay = 1; rsp_byte = 8'h05; rsp_dup = 1;
    run_txn(make_frame(6'd55, 32'h0), 0, 48, 1'b1, mk_rsp(1'b1, NCR_MIN, 8'h05));
    rsp_dup = 0;

`ifdef SD_RESP_CRC7_CHECK_EN
    rsp_en = 1; rsp_delay = 0; rsp_byte = 8'h01;
    run_txn(48'h400000000097, 0, 48, 1'b0, mk_rsp(1'b1, NCR_MIN, 8'h08));
    run_txn(48'h400000000095, 0, 48, 1'b1, mk_rsp(1'b1, NCR_MIN, 8'h01));
`endif

    for (int n = 0; n < 16; n++) begin
      f    = make_frame(6'($urandom_range(0, 63)), $urandom);
      kind = $urandom_range(0, 9);
      pre  = $urandom_range(0, 2);
      r1   = 8'($urandom_range(0, 127));
      rsp_byte  = r1;
      rsp_delay = $urandom_range(0, 40);
      rsp_dup   = ($urandom_range(0, 3) == 0);
      if (kind <= 4) begin
        rsp_en = 1;
        run_txn(f, pre, 48, 1'b1, mk_rsp(1'b1, NCR_MIN, r1));
      end else if (kind <= 6) begin
        rsp_en = 0;
        run_txn(f, pre, 48, 1'b1, mk_rsp(1'b1, NCR_MAX, TIMEOUT_R1));
      end else if (kind == 7) begin
        rsp_en = 1;
        nb = $urandom_range(1, 47);
        run_txn(f, pre, nb, 1'b0, mk_rsp(1'b0, 0, 8'hFF));
      end else begin
        rsp_en = 1;
        if (kind == 8) f[0] = 1'b0;
        else           f[46] = 1'b0;
        run_txn(f, pre, 48, 1'b0, mk_rsp(1'b0, RD_LIMIT, 8'hFF));
      end
    end

    repeat (20) @(negedge clk);
    check("cmd_queue_drained", exp_cmd_q.size(), 0);
    check("rsp_queue_drained", exp_rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
